// File: rtl/ntsc_rx_pkg.sv
// Shared types and default timing for the composite sync separator.
// Line timing assumes 780 samples per line at the CK_EE sample rate.
package ntsc_rx_pkg;

    typedef enum logic [1:0] {
        P_NONE,
        P_EQ,
        P_HS,
        P_BROAD
    } pulse_t;

    typedef enum logic {
        ST_SEARCH,
        ST_LOCK
    } st_t;

    localparam logic [5:0] C_SYNC_TH   = 6'd8;
    localparam int         C_H_TOTAL   = 780;
    localparam int         C_EQ_MIN    = 16;
    localparam int         C_HS_MIN    = 40;
    localparam int         C_HS_MAX    = 80;
    localparam int         C_BROAD_MIN = 200;
    localparam int         C_H_TOL     = 4;
    localparam int         C_LOCK_N    = 8;
    localparam int         C_LOST_N    = 4;
    localparam int         C_VS_LINE   = 6;

endpackage

// File: rtl/ntsc_pulse_class.sv
// Sync-tip slicer, run-length counter and pulse-width classifier.
// The class and its width are presented for one sample after the trailing edge.
module ntsc_pulse_class
    import ntsc_rx_pkg::*;
#(
    parameter logic [5:0] SYNC_TH   = C_SYNC_TH,
    parameter int         EQ_MIN    = C_EQ_MIN,
    parameter int         HS_MIN    = C_HS_MIN,
    parameter int         HS_MAX    = C_HS_MAX,
    parameter int         BROAD_MIN = C_BROAD_MIN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [5:0] video,
    output pulse_t     pulse,
    output logic [8:0] width
);

    localparam logic [8:0] EQ_W    = 9'(EQ_MIN);
    localparam logic [8:0] HSMIN_W = 9'(HS_MIN);
    localparam logic [8:0] HSMAX_W = 9'(HS_MAX);
    localparam logic [8:0] BROAD_W = 9'(BROAD_MIN);

    logic       sync_r;
    logic [8:0] run;
    pulse_t     cls;

    always_comb begin
        cls = P_NONE;
        unique case (1'b1)
            (run < EQ_W):                        cls = P_NONE;
            (run >= EQ_W && run < HSMIN_W):      cls = P_EQ;
            (run >= HSMIN_W && run <= HSMAX_W):  cls = P_HS;
            (run > HSMAX_W && run < BROAD_W):    cls = P_NONE;
            (run >= BROAD_W):                    cls = P_BROAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 1'b0;
            run    <= '0;
            pulse  <= P_NONE;
            width  <= '0;
        end else if (ce) begin
            sync_r <= (video <= SYNC_TH);
            pulse  <= P_NONE;
            if (sync_r) begin
                if (run != 9'h1FF)
                    run <= run + 9'd1;
            end else begin
                run <= '0;
                if (run != '0) begin
                    pulse <= cls;
                    width <= run;
                end
            end
        end
    end

endmodule

// File: rtl/ntsc_sync_sep.sv
// Composite sync separator: H flywheel with lock FSM, V line counter and
// field detection from broad-pulse phase.
module ntsc_sync_sep
    import ntsc_rx_pkg::*;
#(
    parameter logic [5:0] SYNC_TH   = C_SYNC_TH,
    parameter int         H_TOTAL   = C_H_TOTAL,
    parameter int         EQ_MIN    = C_EQ_MIN,
    parameter int         HS_MIN    = C_HS_MIN,
    parameter int         HS_MAX    = C_HS_MAX,
    parameter int         BROAD_MIN = C_BROAD_MIN,
    parameter int         H_TOL     = C_H_TOL,
    parameter int         LOCK_N    = C_LOCK_N,
    parameter int         LOST_N    = C_LOST_N,
    parameter int         VS_LINE   = C_VS_LINE
) (
    input  logic       CK_i,
    input  logic       RST_i,
    input  logic       CK_EE_i,
    input  logic [5:0] VIDEOs_i,
    output logic [9:0] HCTRs_o,
    output logic [9:0] VCTRs_o,
    output logic       HS_o,
    output logic       VS_o,
    output logic       FIELD_o,
    output logic       LOCKED_o
);

    localparam logic [9:0]        H_LAST = 10'(H_TOTAL - 1);
    localparam logic signed [10:0] HT_S  = 11'(H_TOTAL);
    localparam logic signed [10:0] HLF_S = 11'(H_TOTAL / 2);
    localparam logic signed [10:0] Q1_S  = 11'(H_TOTAL / 4);
    localparam logic signed [10:0] Q3_S  = 11'(3 * H_TOTAL / 4);
    localparam logic signed [10:0] TOL_S = 11'(H_TOL);
    localparam logic [3:0]        LOCK_W = 4'(LOCK_N);
    localparam logic [2:0]        LOST_W = 3'(LOST_N);
    localparam logic [9:0]        VS_W   = 10'(VS_LINE);

    pulse_t             pulse;
    logic [8:0]         w;
    st_t                st;
    logic [3:0]         good;
    logic [3:0]         good_next;
    logic [2:0]         miss;
    logic [2:0]         miss_next;
    logic [1:0]         bcnt;
    logic               line_ok;
    logic signed [10:0] diff;
    logic signed [10:0] err;
    logic signed [10:0] lead;
    logic               err_ok;
    logic               is_hs;
    logic               is_broad;
    logic               rephase;
    logic               wrap;
    logic               field_bit;

    ntsc_pulse_class #(
        .SYNC_TH   (SYNC_TH),
        .EQ_MIN    (EQ_MIN),
        .HS_MIN    (HS_MIN),
        .HS_MAX    (HS_MAX),
        .BROAD_MIN (BROAD_MIN)
    ) u_class (
        .clk   (CK_i),
        .rst   (RST_i),
        .ce    (CK_EE_i),
        .video (VIDEOs_i),
        .pulse (pulse),
        .width (w)
    );

    // Phase error folded into one line period, and leading-edge position.
    always_comb begin
        diff = $signed({1'b0, HCTRs_o}) - $signed({2'b00, w});
        err  = diff;
        if (diff >= HLF_S)
            err = diff - HT_S;
        else if (diff < -HLF_S)
            err = diff + HT_S;
        lead = (diff < 11'sd0) ? diff + HT_S : diff;
    end

    assign err_ok    = (err <= TOL_S) && (err >= -TOL_S);
    assign field_bit = (lead >= Q1_S) && (lead < Q3_S);
    assign is_hs     = (pulse == P_HS);
    assign is_broad  = (pulse == P_BROAD);
    assign rephase   = is_hs && ((st == ST_SEARCH) || err_ok);
    assign wrap      = (HCTRs_o == H_LAST);
    assign good_next = err_ok ? good + 4'd1 : 4'd1;
    assign miss_next = miss + 3'd1;

    always_ff @(posedge CK_i or posedge RST_i) begin
        if (RST_i) begin
            HCTRs_o  <= '0;
            VCTRs_o  <= '0;
            HS_o     <= 1'b0;
            VS_o     <= 1'b0;
            FIELD_o  <= 1'b0;
            LOCKED_o <= 1'b0;
            st       <= ST_SEARCH;
            good     <= '0;
            miss     <= '0;
            bcnt     <= '0;
            line_ok  <= 1'b0;
        end else begin
            HS_o <= 1'b0;
            VS_o <= 1'b0;
            if (CK_EE_i) begin
                HS_o <= wrap && !rephase && LOCKED_o;

                if (rephase)
                    HCTRs_o <= {1'b0, w};
                else if (wrap)
                    HCTRs_o <= '0;
                else
                    HCTRs_o <= HCTRs_o + 10'd1;

                if (is_broad && bcnt == 2'd2) begin
                    VS_o    <= 1'b1;
                    VCTRs_o <= VS_W;
                end else if (wrap && VCTRs_o != 10'h3FF) begin
                    VCTRs_o <= VCTRs_o + 10'd1;
                end

                if (is_hs) begin
                    bcnt <= '0;
                end else if (is_broad) begin
                    if (bcnt != 2'd3)
                        bcnt <= bcnt + 2'd1;
                    if (bcnt == 2'd0)
                        FIELD_o <= field_bit;
                end

                unique case (st)
                    ST_SEARCH: begin
                        if (is_hs) begin
                            good <= good_next;
                            if (good_next == LOCK_W) begin
                                st       <= ST_LOCK;
                                LOCKED_o <= 1'b1;
                                miss     <= '0;
                                line_ok  <= 1'b1;
                            end
                        end
                    end
                    ST_LOCK: begin
                        if (wrap) begin
                            line_ok <= 1'b0;
                            if (line_ok || rephase) begin
                                miss <= '0;
                            end else if (miss_next == LOST_W) begin
                                st       <= ST_SEARCH;
                                LOCKED_o <= 1'b0;
                                good     <= '0;
                                miss     <= '0;
                            end else begin
                                miss <= miss_next;
                            end
                        end else if (rephase) begin
                            line_ok <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ntsc_sync_sep.sv
// Directed bench for the sync separator: lock, glitch rejection, field/VS,
// loss of lock and mid-line reset, one sample per two clocks.
module tb_ntsc_sync_sep;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       ce    = 1'b0;
    logic [5:0] video = 6'd40;
    logic [9:0] hctr;
    logic [9:0] vctr;
    logic       hs;
    logic       vs;
    logic       field;
    logic       locked;

    int n_chk   = 0;
    int n_err   = 0;
    int edges   = 0;
    int hs_n    = 0;
    int hs_last = 0;
    int hs_per  = 0;
    int vs_n    = 0;
    int h0      = 0;

    ntsc_sync_sep dut (
        .CK_i     (clk),
        .RST_i    (rst),
        .CK_EE_i  (ce),
        .VIDEOs_i (video),
        .HCTRs_o  (hctr),
        .VCTRs_o  (vctr),
        .HS_o     (hs),
        .VS_o     (vs),
        .FIELD_o  (field),
        .LOCKED_o (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ce && !rst)
            edges++;

    always @(negedge clk) begin
        if (hs) begin
            if (hs_n > 0)
                hs_per = edges - hs_last;
            hs_last = edges;
            hs_n++;
        end
        if (vs)
            vs_n++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic seg(input logic [5:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            video = v;
            ce    = 1'b1;
            @(negedge clk);
            ce    = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic line(input int wd);
        seg(6'd0, wd);
        seg(6'd40, 780 - wd);
    endtask

    task automatic broad3();
        repeat (3) begin
            seg(6'd0, 330);
            seg(6'd40, 60);
        end
    endtask

    task automatic outs_zero(input string t);
        check({t, "_hctr"}, int'(hctr), 0);
        check({t, "_vctr"}, int'(vctr), 0);
        check({t, "_hs"}, int'(hs), 0);
        check({t, "_vs"}, int'(vs), 0);
        check({t, "_field"}, int'(field), 0);
        check({t, "_locked"}, int'(locked), 0);
    endtask

    task automatic lock_seq(input string t);
        repeat (7) line(58);
        check({t, "_hctr7"}, int'(hctr), 777);
        check({t, "_lock7"}, int'(locked), 0);
        seg(6'd0, 58);
        seg(6'd40, 2);
        check({t, "_hctr_pre"}, int'(hctr), 57);
        check({t, "_lock_pre"}, int'(locked), 0);
        seg(6'd40, 1);
        check({t, "_hctr_post"}, int'(hctr), 58);
        check({t, "_lock_post"}, int'(locked), 1);
        seg(6'd40, 780 - 61);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        outs_zero("rst");
        rst   = 1'b0;
        video = 6'd0;
        repeat (20) @(negedge clk);
        check("hold_hctr", int'(hctr), 0);
        check("hold_lock", int'(locked), 0);

        lock_seq("lock");
        repeat (4) line(58);
        check("run_hs_n", hs_n, 4);
        check("run_hs_per", hs_per, 780);
        check("run_vctr", int'(vctr), 11);
        check("run_hctr", int'(hctr), 777);

        seg(6'd0, 58);
        seg(6'd40, 142);
        seg(6'd0, 10);
        seg(6'd40, 140);
        seg(6'd0, 30);
        seg(6'd40, 170);
        seg(6'd0, 50);
        seg(6'd40, 180);
        check("glitch_hctr", int'(hctr), 777);
        check("glitch_lock", int'(locked), 1);

        seg(6'd40, 3);
        broad3();
        check("vs1_n", vs_n, 1);
        check("vs1_field", int'(field), 0);
        check("vs1_vctr", int'(vctr), 6);
        check("vs1_lock", int'(locked), 1);
        check("vs1_hctr", int'(hctr), 390);

        seg(6'd40, 390);
        line(58);
        seg(6'd40, 393);
        broad3();
        check("vs2_n", vs_n, 2);
        check("vs2_field", int'(field), 1);
        check("vs2_vctr", int'(vctr), 7);
        check("vs2_lock", int'(locked), 1);
        check("vs2_hctr", int'(hctr), 0);

        line(58);
        line(58);
        check("pre_lost_hctr", int'(hctr), 777);
        h0 = hs_n;
        seg(6'd40, 3122);
        check("lost_before", int'(locked), 1);
        seg(6'd40, 1);
        check("lost_after", int'(locked), 0);
        check("lost_hs_last", hs_last, 18729);
        check("lost_hs_per", hs_per, 780);
        check("lost_hs_n", hs_n - h0, 5);
        seg(6'd40, 800);
        check("search_hs_n", hs_n - h0, 5);
        check("search_lock", int'(locked), 0);

        repeat (8) line(58);
        check("relock_lock", int'(locked), 1);
        check("relock_hctr", int'(hctr), 777);
        seg(6'd40, 403);
        check("mid_hctr", int'(hctr), 400);
        check("mid_lock", int'(locked), 1);
        check("mid_field", int'(field), 1);

        rst = 1'b1;
        @(negedge clk);
        outs_zero("midrst");
        rst = 1'b0;
        @(negedge clk);
        h0 = hs_n;
        lock_seq("relock2");
        check("relock2_hs_n", hs_n - h0, 0);
        check("relock2_vs_n", vs_n, 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
